// File: rtl/sparse_mask_combiner.sv
// sparse_mask_combiner
//   Frames of IN_LEN multi-lane words come in and OUT_LEN words go out.
//   Output row k is the lane-wise combination (XOR, or add mod 2^LANE_W)
//   of every input word j whose mask bit (k*IN_LEN + j) is set. The mask is
//   captured on beat 0 and held for the rest of the frame. The block never
//   accepts input while it is emitting, so frames do not overlap.
// Ports
//   i_clock / i_reset_n           clock, async active-low reset
//   i_row_mask [OUT_LEN*IN_LEN]   sparse selection mask, sampled on beat 0
//   i_flush                       synchronous abort of the current frame
//   i_input_data/valid, o_input_ready     upstream stream (lane 0 in LSBs)
//   o_output_data/valid, i_output_ready   downstream stream

// Lane combiner: one LANE_W-wide slice of the accumulate operation.
module sparse_mask_combiner_lane #(
    parameter int LANE_W = 32,
    parameter int MODE   = 0
) (
    input  logic [LANE_W-1:0] a_i,
    input  logic [LANE_W-1:0] b_i,
    output logic [LANE_W-1:0] y_o
);
    generate
        if (MODE == 1) begin : g_add
            // Truncating add: carries never leave the lane.
            assign y_o = a_i + b_i;
        end else begin : g_xor
            assign y_o = a_i ^ b_i;
        end
    endgenerate
endmodule

module sparse_mask_combiner #(
    parameter int LANES   = 3,
    parameter int LANE_W  = 32,
    parameter int IN_LEN  = 11,
    parameter int OUT_LEN = 1,
    parameter int MODE    = 0
) (
    input  logic                        i_clock,
    input  logic                        i_reset_n,
    input  logic [OUT_LEN*IN_LEN-1:0]   i_row_mask,
    input  logic                        i_flush,
    input  logic [LANES*LANE_W-1:0]     i_input_data,
    input  logic                        i_input_valid,
    output logic                        o_input_ready,
    output logic [LANES*LANE_W-1:0]     o_output_data,
    output logic                        o_output_valid,
    input  logic                        i_output_ready
);
    localparam int ICW = $clog2(IN_LEN + 1);
    localparam int OCW = $clog2(OUT_LEN + 1);

    typedef enum logic {ACCUM, EMIT} state_t;

    state_t                                       state_q;
    logic [ICW-1:0]                               in_cnt_q;
    logic [OCW-1:0]                               out_cnt_q;
    logic [OUT_LEN*IN_LEN-1:0]                    mask_q;
    logic [OUT_LEN-1:0][LANES-1:0][LANE_W-1:0]    acc_q;
    logic [OUT_LEN-1:0][LANES-1:0][LANE_W-1:0]    acc_d;
    logic                                         in_rdy_q;
    logic                                         out_vld_q;

    logic [OUT_LEN*IN_LEN-1:0] cur_mask;
    logic [OUT_LEN-1:0]        hit;
    logic                      in_acc, out_acc, last_in, last_out;

    // Beat 0 uses the live mask; later beats use the copy latched on beat 0.
    assign cur_mask = (in_cnt_q == '0) ? i_row_mask : mask_q;
    assign in_acc   = i_input_valid && in_rdy_q;
    assign out_acc  = out_vld_q && i_output_ready;
    assign last_in  = (in_cnt_q == ICW'(IN_LEN - 1));
    assign last_out = (out_cnt_q == OCW'(OUT_LEN - 1));

    // Which rows take the current beat.
    always_comb begin
        hit = '0;
        for (int k = 0; k < OUT_LEN; k++)
            for (int j = 0; j < IN_LEN; j++)
                if (in_cnt_q == ICW'(j)) hit[k] = cur_mask[k*IN_LEN + j];
    end

    generate
        for (genvar gk = 0; gk < OUT_LEN; gk++) begin : g_row
            for (genvar gl = 0; gl < LANES; gl++) begin : g_lane
                sparse_mask_combiner_lane #(.LANE_W(LANE_W), .MODE(MODE)) u_lane (
                    .a_i (acc_q[gk][gl]),
                    .b_i (i_input_data[gl*LANE_W +: LANE_W]),
                    .y_o (acc_d[gk][gl])
                );
            end
        end
    endgenerate

    // Output word is a pure selection of registered accumulators.
    always_comb begin
        o_output_data = '0;
        for (int k = 0; k < OUT_LEN; k++)
            if (out_cnt_q == OCW'(k)) o_output_data = acc_q[k];
    end

    assign o_input_ready  = in_rdy_q;
    assign o_output_valid = out_vld_q;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= ACCUM;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            mask_q    <= '0;
            acc_q     <= '0;
            in_rdy_q  <= 1'b0;
            out_vld_q <= 1'b0;
        end else if (i_flush) begin
            // Abort wins over any handshake on the same edge.
            state_q   <= ACCUM;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            acc_q     <= '0;
            in_rdy_q  <= 1'b1;
            out_vld_q <= 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    in_rdy_q <= 1'b1;
                    if (in_acc) begin
                        if (in_cnt_q == '0) mask_q <= i_row_mask;
                        for (int k = 0; k < OUT_LEN; k++)
                            if (hit[k]) acc_q[k] <= acc_d[k];
                        if (last_in) begin
                            state_q   <= EMIT;
                            in_rdy_q  <= 1'b0;
                            out_vld_q <= 1'b1;
                            out_cnt_q <= '0;
                        end else begin
                            in_cnt_q <= in_cnt_q + ICW'(1);
                        end
                    end
                end
                EMIT: begin
                    if (out_acc) begin
                        if (last_out) begin
                            state_q   <= ACCUM;
                            acc_q     <= '0;
                            in_cnt_q  <= '0;
                            out_vld_q <= 1'b0;
                            in_rdy_q  <= 1'b1;
                        end else begin
                            out_cnt_q <= out_cnt_q + OCW'(1);
                        end
                    end
                end
                default: state_q <= ACCUM;
            endcase
        end
    end
endmodule

// File: tb/tb_sparse_mask_combiner.sv
// Bench for sparse_mask_combiner: three instances (XOR 11x1, ADD 11x1,
// XOR 4x2) share clock, reset, flush, data and downstream ready. Inputs are
// driven 1 time unit after a rising edge; outputs are observed on the
// falling edge by a scoreboard fed from a lane-level reference model.
module tb_sparse_mask_combiner;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        ordy = 1'b1;
    logic [95:0] din;
    logic [10:0] mask0, mask1;
    logic [7:0]  mask2;
    logic        vin[3];
    logic        ir[3];
    logic        ov[3];
    logic [95:0] od[3];

    logic [95:0] exp_q[3][$];
    int          nvec = 0;
    int          nerr = 0;
    int          nout[3];
    logic [95:0] fw[16];
    bit          pv[3];
    logic [95:0] pd[3];
    bit          pr, pf;
    bit          busy;

    always #5 clk = ~clk;

    sparse_mask_combiner #(.MODE(0)) u_x (
        .i_clock(clk), .i_reset_n(rst_n), .i_row_mask(mask0), .i_flush(flush),
        .i_input_data(din), .i_input_valid(vin[0]), .o_input_ready(ir[0]),
        .o_output_data(od[0]), .o_output_valid(ov[0]), .i_output_ready(ordy));

    sparse_mask_combiner #(.MODE(1)) u_a (
        .i_clock(clk), .i_reset_n(rst_n), .i_row_mask(mask1), .i_flush(flush),
        .i_input_data(din), .i_input_valid(vin[1]), .o_input_ready(ir[1]),
        .o_output_data(od[1]), .o_output_valid(ov[1]), .i_output_ready(ordy));

    sparse_mask_combiner #(.IN_LEN(4), .OUT_LEN(2), .MODE(0)) u_s (
        .i_clock(clk), .i_reset_n(rst_n), .i_row_mask(mask2), .i_flush(flush),
        .i_input_data(din), .i_input_valid(vin[2]), .o_input_ready(ir[2]),
        .o_output_data(od[2]), .o_output_valid(ov[2]), .i_output_ready(ordy));

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference lane operation: independent 32-bit lanes.
    function automatic logic [95:0] op(input int mode, input logic [95:0] a, input logic [95:0] b);
        logic [95:0] r;
        for (int l = 0; l < 3; l++)
            r[l*32 +: 32] = (mode == 1) ? a[l*32 +: 32] + b[l*32 +: 32]
                                        : a[l*32 +: 32] ^ b[l*32 +: 32];
        return r;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic rand_frame();
        for (int j = 0; j < 16; j++) fw[j] = {$urandom, $urandom, $urandom};
    endtask

    task automatic beat(input int d, input logic [95:0] w, input logic [10:0] m);
        int t;
        t = 0;
        din = w;
        case (d)
            0: mask0 = m;
            1: mask1 = m;
            default: mask2 = m[7:0];
        endcase
        vin[d] = 1'b1;
        while (!ir[d] && t < 200) begin @(posedge clk); #1; t++; end
        if (t >= 200) chk("beat_timeout", 96'(ir[d]), 96'd1);
        @(posedge clk); #1;
        vin[d] = 1'b0;
    endtask

    // Feed fw[] as one frame, then queue the rows the mask of beat 0 selects.
    task automatic send_frame(input int d, input logic [10:0] m0, input logic [10:0] mr, input int gmax);
        int n, rows, mode;
        logic [95:0] acc;
        n    = (d == 2) ? 4 : 11;
        rows = (d == 2) ? 2 : 1;
        mode = (d == 1) ? 1 : 0;
        for (int j = 0; j < n; j++) begin
            idle($urandom_range(0, gmax));
            beat(d, fw[j], (j == 0) ? m0 : mr);
        end
        chk($sformatf("latency_d%0d", d), 96'(ov[d]), 96'd1);
        for (int k = 0; k < rows; k++) begin
            acc = '0;
            for (int j = 0; j < n; j++)
                if (m0[k*n + j]) acc = op(mode, acc, fw[j]);
            exp_q[d].push_back(acc);
        end
    endtask

    // Scoreboard / protocol monitor.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (!rst_n) begin
                pv[d] = 1'b0;
            end else begin
                if (pv[d] && !pr && !pf) begin
                    chk($sformatf("hold_vld_d%0d", d), 96'(ov[d]), 96'd1);
                    chk($sformatf("hold_data_d%0d", d), od[d], pd[d]);
                end
                if (ov[d]) begin
                    if (exp_q[d].size() == 0)
                        chk($sformatf("spurious_d%0d", d), 96'(ov[d]), 96'd0);
                    else if (ordy) begin
                        chk($sformatf("row_d%0d", d), od[d], exp_q[d].pop_front());
                        nout[d]++;
                    end
                end
                pv[d] = ov[d];
                pd[d] = od[d];
            end
        end
        pr = ordy;
        pf = flush;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int base;
        for (int d = 0; d < 3; d++) begin vin[d] = 1'b0; nout[d] = 0; pv[d] = 1'b0; end
        din = '0; mask0 = '0; mask1 = '0; mask2 = '0;
        #12;
        for (int d = 0; d < 3; d++) begin
            chk("reset_irdy", 96'(ir[d]), 96'd0);
            chk("reset_ovld", 96'(ov[d]), 96'd0);
            chk("reset_data", od[d], 96'd0);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        for (int d = 0; d < 3; d++) chk("irdy_after_reset", 96'(ir[d]), 96'd1);

        // Idle: nothing comes out without input.
        repeat (10) begin chk("idle_ovld", 96'(ov[0]), 96'd0); idle(1); end

        // Default mask reproduces the last word of the frame.
        rand_frame();
        fw[10] = {32'd67108896, 32'd65536, 32'd134217792};
        send_frame(0, 11'h400, 11'h400, 0);
        idle(3);

        // XOR of words 0 and 1 only.
        rand_frame();
        for (int j = 0; j < 11; j++) fw[j] = '1;
        fw[0] = 96'd5; fw[1] = 96'd3;
        send_frame(0, 11'h003, 11'h003, 0);
        idle(3);
        // Mask changes after beat 0 must be ignored.
        rand_frame();
        send_frame(0, 11'h003, 11'h7FF, 1);
        idle(3);

        // Modular add: lane 2 wraps without carrying anywhere.
        rand_frame();
        fw[0] = {32'hFFFFFFFF, 32'd0, 32'd1};
        fw[1] = {32'd2, 32'd0, 32'd1};
        send_frame(1, 11'h003, 11'h003, 0);
        idle(3);

        // Two output rows held under backpressure.
        ordy = 1'b0;
        rand_frame();
        send_frame(2, 11'h0C3, 11'h0C3, 0);
        repeat (5) begin
            chk("bp_irdy", 96'(ir[2]), 96'd0);
            chk("bp_ovld", 96'(ov[2]), 96'd1);
            idle(1);
        end
        base = nout[2];
        ordy = 1'b1;
        idle(2);
        chk("bp_rows_out", 96'(nout[2] - base), 96'd2);
        chk("bp_irdy_back", 96'(ir[2]), 96'd1);
        chk("bp_ovld_low", 96'(ov[2]), 96'd0);

        // Five frames with gaps, the fourth all zero.
        base = nout[0];
        for (int f = 0; f < 5; f++) begin
            rand_frame();
            if (f == 3) for (int j = 0; j < 16; j++) fw[j] = '0;
            send_frame(0, 11'($urandom), 11'($urandom), 3);
        end
        idle(5);
        chk("frame_count", 96'(nout[0] - base), 96'd5);

        // Random frames with random downstream ready.
        busy = 1'b1;
        fork
            begin
                while (busy) begin @(posedge clk); #1; ordy = 1'($urandom_range(0, 1)); end
                ordy = 1'b1;
            end
        join_none
        for (int f = 0; f < 3; f++) begin
            rand_frame(); send_frame(2, 11'($urandom), 11'($urandom), 2);
            rand_frame(); send_frame(1, 11'($urandom), 11'($urandom), 2);
        end
        busy = 1'b0;
        idle(20);

        // Flush after 6 beats; the beat offered with the flush is dropped.
        for (int j = 0; j < 6; j++) beat(0, {$urandom, $urandom, $urandom}, 11'h7FF);
        flush = 1'b1; din = {$urandom, $urandom, $urandom}; vin[0] = 1'b1;
        idle(1);
        flush = 1'b0; vin[0] = 1'b0;
        chk("flush_ovld", 96'(ov[0]), 96'd0);
        chk("flush_irdy", 96'(ir[0]), 96'd1);
        rand_frame();
        send_frame(0, 11'h7FF, 11'h7FF, 0);
        idle(3);

        // Reset while a result is waiting.
        ordy = 1'b0;
        rand_frame();
        send_frame(2, 11'h0A5, 11'h0A5, 0);
        idle(2);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_ovld", 96'(ov[2]), 96'd0);
        chk("async_rst_irdy", 96'(ir[2]), 96'd0);
        chk("async_rst_data", od[2], 96'd0);
        exp_q[2].delete();
        ordy = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        rand_frame();
        send_frame(2, 11'($urandom), 11'($urandom), 1);
        idle(4);

        for (int d = 0; d < 3; d++) chk("leftover", 96'(exp_q[d].size()), 96'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
